instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter INITIAL_PC, default 32'h00000000, is the first fetch address after reset.
REQ-002 Parameter FETCH_DEPTH, default 2, is the instruction buffer depth; only 2 is required to be supported.
REQ-003 Port clock  input  1  is the single clock; all state is updated on its rising edge.
REQ-004 Port reset  input  1  is the reset: asynchronous, active-low (0 = reset).
REQ-005 Port redirectValid  input  1  requests a fetch redirect for this cycle.
REQ-006 Port redirectAddress  input  32  is the new fetch address, valid when redirectValid=1.
REQ-007 Port memRequestValid  output  1  is the instruction-memory read request.
REQ-008 Port memRequestReady  input  1  indicates memory accepts the request this cycle.
REQ-009 Port memRequestAddress  output  32  is the word address of the request.
REQ-010 Port memResponseValid  input  1  indicates read data is returned, in request order.
REQ-011 Port memResponseData  input  32  is the returned instruction word.
REQ-012 Port instructionValid  output  1  indicates the buffer head holds an instruction.
REQ-013 Port instructionReady  input  1  indicates the decode stage consumes the head this cycle.
REQ-014 Port instruction  output  32  is the buffer-head instruction.
REQ-015 Port pcOfInstruction  output  32  is the PC of the buffer-head instruction.
REQ-016 Port fetchMisaligned  output  1  is high while the fetch PC has bits [1:0] != 2'b00.

Function
REQ-017 The block SHALL hold registers fetchPc, responsePc, inFlight (0..2) and discardCount (0..2), plus the instruction buffer.
REQ-018 A request handshake SHALL occur when memRequestValid=1 and memRequestReady=1; on handshake fetchPc += 4 (modulo 2^32 wrap) and inFlight += 1.
REQ-019 memRequestValid SHALL be 1 iff redirectValid=0, fetchMisaligned=0, inFlight<2, and (bufferCount + inFlight - discardCount) < FETCH_DEPTH, using registered state only (no combinational path from instructionReady or memResponseValid).
REQ-020 memRequestAddress SHALL equal fetchPc at all times.
REQ-021 On memResponseValid=1 with discardCount>0 the response SHALL be dropped and discardCount decremented.
REQ-022 On memResponseValid=1 with discardCount=0 the block SHALL push {responsePc, memResponseData} into the buffer and increment responsePc by 4.
REQ-023 A pushed entry SHALL appear on instructionValid/instruction/pcOfInstruction the cycle after the response (1-cycle latency).
REQ-024 The head SHALL be popped when instructionValid=1 and instructionReady=1; push and pop in the same cycle SHALL both take effect.
REQ-025 inFlight SHALL decrement on every response (kept or dropped); simultaneous request and response SHALL leave inFlight unchanged.
REQ-026 On redirectValid=1: buffer flushed (instructionValid=0 next cycle), fetchPc and responsePc <= redirectAddress, discardCount <= inFlight minus 1 if memResponseValid=1 this cycle, inFlight updated the same way; a response in that cycle SHALL be dropped.
REQ-027 A redirect to a misaligned address SHALL set fetchPc, assert fetchMisaligned and stall requests until a later aligned redirect; outstanding responses SHALL still be drained and discarded.
REQ-028 Responses arriving with inFlight=0 are illegal; no behaviour is required.

Reset
REQ-029 While reset=0: fetchPc=responsePc=INITIAL_PC, inFlight=discardCount=0, buffer empty.
REQ-030 Reset outputs: memRequestValid=0, memRequestAddress=INITIAL_PC, instructionValid=0, instruction=0, pcOfInstruction=0, fetchMisaligned=INITIAL_PC[1:0]!=0.
REQ-031 The first request SHALL be presented in the first clock cycle after reset deasserts; reset mid-operation SHALL abandon all in-flight requests.

Structure
REQ-032 The shared core package SHALL hold FETCH_DEPTH and the typedef struct fetch_entry_t {pc[31:0], instruction[31:0]}.
REQ-033 The buffer SHALL be a sub-module named fetch_buffer (FIFO of fetch_entry_t with push, pop, flush, count).

Verification
REQ-034 Reset release, memRequestReady=1, 1-cycle response latency -> requests 0x0,0x4,0x8 in consecutive cycles; instructionValid with pcOfInstruction 0x0 two cycles after release.
REQ-035 instructionReady=0 held -> exactly 2 entries buffered, memRequestValid=0, no further requests until a pop.
REQ-036 Two requests outstanding (0x8, 0xC), redirect to 0x100 -> both responses dropped, next delivered entry has pcOfInstruction=0x100.
REQ-037 Redirect coincident with response of 0x8 -> that response dropped, discardCount=remaining inFlight, first delivered pc=redirectAddress.
REQ-038 Redirect to 0x102 -> fetchMisaligned=1, memRequestValid=0; redirect to 0x200 -> fetchMisaligned=0, request 0x200 issued next cycle.
REQ-039 Redirect to 0xFFFFFFFC -> requests 0xFFFFFFFC then 0x00000000 (wrap).

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   FETCH_DEPTH    : instruction buffer depth (entries)
//   FETCH_STRIDE   : byte distance between consecutive fetch words
//   fetch_entry_t  : one buffered instruction with its PC
//   is_misaligned  : true when an address is not word aligned
package instruction_fetch_unit_pkg;

    localparam int unsigned FETCH_DEPTH  = 2;
    localparam logic [31:0] FETCH_STRIDE = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit and its environment.
//   redirect : redirectValid / redirectAddress (environment -> fetch)
//   memory   : memRequestValid / memRequestAddress out, memRequestReady,
//              memResponseValid / memResponseData in
//   decode   : instructionValid / instruction / pcOfInstruction out,
//              instructionReady in
//   status   : fetchMisaligned out
// modport master is the fetch unit side, modport slave the environment side.
interface instruction_fetch_unit_if;

    logic        redirectValid;
    logic [31:0] redirectAddress;
    logic        memRequestValid;
    logic        memRequestReady;
    logic [31:0] memRequestAddress;
    logic        memResponseValid;
    logic [31:0] memResponseData;
    logic        instructionValid;
    logic        instructionReady;
    logic [31:0] instruction;
    logic [31:0] pcOfInstruction;
    logic        fetchMisaligned;

    modport master (
        input  redirectValid, redirectAddress, memRequestReady,
               memResponseValid, memResponseData, instructionReady,
        output memRequestValid, memRequestAddress, instructionValid,
               instruction, pcOfInstruction, fetchMisaligned
    );

    modport slave (
        output redirectValid, redirectAddress, memRequestReady,
               memResponseValid, memResponseData, instructionReady,
        input  memRequestValid, memRequestAddress, instructionValid,
               instruction, pcOfInstruction, fetchMisaligned
    );

endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO of fetch_entry_t holding fetched instructions for decode.
//   clock/reset : rising-edge clock, async active-low reset
//   push_valid/push_entry : write one entry (ignored when full and not popping)
//   pop         : consume the head entry (ignored when empty)
//   flush       : empty the FIFO; wins over push and pop in the same cycle
//   head_valid/head_entry : head of the FIFO, entry forced to zero when empty
//   count       : number of stored entries
module fetch_buffer
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_valid,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       head_valid,
    output fetch_entry_t               head_entry,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    fetch_entry_t     entries_q [DEPTH];
    fetch_entry_t     entries_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        entries_d = entries_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        pop_ok_s  = pop && (count_q != {CNT_W{1'b0}});
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok_s = push_valid && ((count_q != FULL_COUNT) || pop_ok_s);
        if (flush) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                entries_d[wr_ptr_q] = push_entry;
                wr_ptr_d            = next_ptr(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    // FIFO state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            entries_q <= entries_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    assign head_valid = (count_q != {CNT_W{1'b0}});
    assign head_entry = head_valid ? entries_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues sequential word reads to instruction memory,
// buffers the returned words with their PCs for decode, and handles redirects
// by flushing the buffer and discarding responses still in flight.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : instruction_fetch_unit_if.master (redirect, memory, decode, status)
// Parameters: INITIAL_PC (first fetch address), FETCH_DEPTH (buffer entries).
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] INITIAL_PC  = 32'h0000_0000,
    parameter int unsigned FETCH_DEPTH = instruction_fetch_unit_pkg::FETCH_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(FETCH_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 2;
    localparam logic [OCC_W-1:0] DEPTH_LIMIT   = OCC_W'(FETCH_DEPTH);
    localparam logic [1:0]       MAX_IN_FLIGHT = 2'd2;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      response_pc_q, response_pc_d;
    logic [1:0]       in_flight_q, in_flight_d;
    logic [1:0]       discard_count_q, discard_count_d;

    logic [CNT_W-1:0] buf_count_s;
    logic [OCC_W-1:0] occupancy_s;
    logic             misaligned_s;
    logic             req_valid_s;
    logic             handshake_s;
    logic             response_s;
    logic [1:0]       in_flight_left_s;
    logic             push_s;
    logic             pop_s;
    logic             flush_s;
    logic             head_valid_s;
    fetch_entry_t     head_entry_s;
    fetch_entry_t     push_entry_s;

    // Request qualification. Occupancy counts buffered entries plus responses
    // that will still be kept, so every request is guaranteed a buffer slot.
    // Only registered state and the redirect/reset inputs are used here.
    always_comb begin
        misaligned_s = is_misaligned(fetch_pc_q);
        occupancy_s  = OCC_W'(buf_count_s) + OCC_W'(in_flight_q) - OCC_W'(discard_count_q);
        req_valid_s  = reset && !bus.redirectValid && !misaligned_s
                       && (in_flight_q < MAX_IN_FLIGHT) && (occupancy_s < DEPTH_LIMIT);
        handshake_s  = req_valid_s && bus.memRequestReady;
    end

    // Next-state for PCs, in-flight tracking and buffer control.
    always_comb begin
        fetch_pc_d      = fetch_pc_q;
        response_pc_d   = response_pc_q;
        in_flight_d     = in_flight_q;
        discard_count_d = discard_count_q;
        push_s          = 1'b0;
        flush_s         = 1'b0;
        // A response with nothing in flight is ignored so the counters never wrap.
        response_s       = bus.memResponseValid && (in_flight_q != 2'd0);
        in_flight_left_s = in_flight_q - {1'b0, response_s};
        push_entry_s     = '{pc: response_pc_q, instruction: bus.memResponseData};
        pop_s            = head_valid_s && bus.instructionReady;

        if (bus.redirectValid) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            fetch_pc_d      = bus.redirectAddress;
            response_pc_d   = bus.redirectAddress;
            in_flight_d     = in_flight_left_s;
            discard_count_d = in_flight_left_s;
            flush_s         = 1'b1;
        end else begin
            if (handshake_s) begin
                fetch_pc_d = fetch_pc_q + FETCH_STRIDE;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            in_flight_d = in_flight_left_s + {1'b0, handshake_s};
            if (response_s) begin
                if (discard_count_q != 2'd0) begin
                    discard_count_d = discard_count_q - 2'd1;
                end else begin
                    push_s        = 1'b1;
                    response_pc_d = response_pc_q + FETCH_STRIDE;
                end
            end else begin
                discard_count_d = discard_count_q;
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q      <= INITIAL_PC;
            response_pc_q   <= INITIAL_PC;
            in_flight_q     <= 2'd0;
            discard_count_q <= 2'd0;
        end else begin
            fetch_pc_q      <= fetch_pc_d;
            response_pc_q   <= response_pc_d;
            in_flight_q     <= in_flight_d;
            discard_count_q <= discard_count_d;
        end
    end

    fetch_buffer #(
        .DEPTH (FETCH_DEPTH)
    ) u_buffer (
        .clock      (clock),
        .reset      (reset),
        .push_valid (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (flush_s),
        .head_valid (head_valid_s),
        .head_entry (head_entry_s),
        .count      (buf_count_s)
    );

    assign bus.memRequestValid   = req_valid_s;
    assign bus.memRequestAddress = fetch_pc_q;
    assign bus.fetchMisaligned   = misaligned_s;
    assign bus.instructionValid  = head_valid_s;
    assign bus.instruction       = head_entry_s.instruction;
    assign bus.pcOfInstruction   = head_entry_s.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [31:0] DATA_KEY = 32'h1357_9BDF;

    typedef struct {
        logic        inst_ready;
        logic        exp_rv;
        logic [31:0] exp_ra;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .INITIAL_PC  (32'h0000_0000),
        .FETCH_DEPTH (2)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] pend_q [$];
    logic [31:0] req_log [$];
    logic [31:0] pop_pc_log [$];
    logic [31:0] pop_data_log [$];
    logic        mem_hold   = 1'b0;
    logic        inst_ready = 1'b1;
    logic        s_rv, s_iv, s_mis;
    logic [31:0] s_ra, s_ipc, s_inst;
    vec_t        vecs [9];

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] ra,
                                input logic iv, input logic [31:0] pc);
        vec_t v;
        v.inst_ready = r;
        v.exp_rv     = rv;
        v.exp_ra     = ra;
        v.exp_iv     = iv;
        v.exp_pc     = pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, sample outputs 1ns later,
    // update the memory model at posedge (1-cycle response latency, in order).
    task automatic cycle(input logic redir, input logic [31:0] raddr);
        logic resp;
        logic hs;
        bus.redirectValid    = redir;
        bus.redirectAddress  = raddr;
        bus.instructionReady = inst_ready;
        bus.memRequestReady  = 1'b1;
        resp = !mem_hold && (pend_q.size() > 0);
        bus.memResponseValid = resp;
        bus.memResponseData  = resp ? (pend_q[0] ^ DATA_KEY) : 32'h0;
        #1;
        s_rv   = bus.memRequestValid;
        s_ra   = bus.memRequestAddress;
        s_iv   = bus.instructionValid;
        s_ipc  = bus.pcOfInstruction;
        s_inst = bus.instruction;
        s_mis  = bus.fetchMisaligned;
        hs = s_rv && bus.memRequestReady;
        if (hs) req_log.push_back(s_ra);
        if (s_iv && inst_ready) begin
            pop_pc_log.push_back(s_ipc);
            pop_data_log.push_back(s_inst);
        end
        @(posedge clk);
        if (resp) void'(pend_q.pop_front());
        if (hs) pend_q.push_back(s_ra);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n                = 1'b0;
        bus.redirectValid    = 1'b0;
        bus.redirectAddress  = 32'h0;
        bus.memRequestReady  = 1'b1;
        bus.memResponseValid = 1'b0;
        bus.memResponseData  = 32'h0;
        bus.instructionReady = 1'b1;
        pend_q.delete();
        mem_hold   = 1'b0;
        inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_rst_req_valid"}, 32'(bus.memRequestValid), 32'd0);
        check({tag, "_rst_req_addr"},  bus.memRequestAddress,    32'h0);
        check({tag, "_rst_inst_valid"}, 32'(bus.instructionValid), 32'd0);
        check({tag, "_rst_inst"},      bus.instruction,          32'h0);
        check({tag, "_rst_pc"},        bus.pcOfInstruction,      32'h0);
        check({tag, "_rst_misaligned"}, 32'(bus.fetchMisaligned), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_pc_log.delete();
        pop_data_log.delete();
    endtask

    initial begin
        // Streaming from reset, then decode stalls with the buffer full.
        vecs[0] = mk(1'b1, 1'b1, 32'h0,  1'b0, 32'h0);
        vecs[1] = mk(1'b1, 1'b1, 32'h4,  1'b0, 32'h0);
        vecs[2] = mk(1'b1, 1'b0, 32'h8,  1'b1, 32'h0);
        vecs[3] = mk(1'b0, 1'b1, 32'h8,  1'b1, 32'h4);
        vecs[4] = mk(1'b0, 1'b0, 32'hC,  1'b1, 32'h4);
        vecs[5] = mk(1'b0, 1'b0, 32'hC,  1'b1, 32'h4);
        vecs[6] = mk(1'b1, 1'b0, 32'hC,  1'b1, 32'h4);
        vecs[7] = mk(1'b0, 1'b1, 32'hC,  1'b1, 32'h8);
        vecs[8] = mk(1'b0, 1'b0, 32'h10, 1'b1, 32'h8);

        do_reset("boot");
        for (int i = 0; i < 9; i++) begin
            inst_ready = vecs[i].inst_ready;
            cycle(1'b0, 32'h0);
            check($sformatf("v%0d_req_valid", i), 32'(s_rv), 32'(vecs[i].exp_rv));
            check($sformatf("v%0d_req_addr", i),  s_ra,       vecs[i].exp_ra);
            check($sformatf("v%0d_inst_valid", i), 32'(s_iv), 32'(vecs[i].exp_iv));
            check($sformatf("v%0d_pc", i),        s_ipc,      vecs[i].exp_pc);
            check($sformatf("v%0d_inst", i),      s_inst,
                  vecs[i].exp_iv ? (vecs[i].exp_pc ^ DATA_KEY) : 32'h0);
        end

        // Redirect with a full buffer flushes it.
        inst_ready = 1'b0;
        cycle(1'b1, 32'h40);
        check("flush_pre_valid", 32'(s_iv), 32'd1);
        check("flush_pre_req", 32'(s_rv), 32'd0);
        inst_ready = 1'b1;
        cycle(1'b0, 32'h0);
        check("flush_post_valid", 32'(s_iv), 32'd0);
        check("flush_post_req", 32'(s_rv), 32'd1);
        check("flush_post_addr", s_ra, 32'h40);
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        check("flush_first_valid", 32'(s_iv), 32'd1);
        check("flush_first_pc", s_ipc, 32'h40);
        check("flush_first_inst", s_inst, 32'h40 ^ DATA_KEY);

        // Redirect with two requests outstanding and no coincident response.
        do_reset("outstanding");
        mem_hold = 1'b1;
        cycle(1'b0, 32'h0);
        check("out_req0", s_ra, 32'h0);
        cycle(1'b0, 32'h0);
        check("out_req1", s_ra, 32'h4);
        cycle(1'b1, 32'h100);
        check("out_redirect_req_valid", 32'(s_rv), 32'd0);
        mem_hold = 1'b0;
        clear_logs();
        for (int k = 0; k < 20 && pop_pc_log.size() == 0; k++) cycle(1'b0, 32'h0);
        check("out_delivered", 32'(pop_pc_log.size() != 0), 32'd1);
        check("out_first_req", req_log[0], 32'h100);
        check("out_first_pc", pop_pc_log[0], 32'h100);
        check("out_first_inst", pop_data_log[0], 32'h100 ^ DATA_KEY);

        // Redirect coincident with a response; one more still in flight.
        do_reset("coincident");
        mem_hold = 1'b1;
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        mem_hold = 1'b0;
        cycle(1'b1, 32'h300);
        clear_logs();
        cycle(1'b0, 32'h0);
        check("coin_req_valid", 32'(s_rv), 32'd1);
        check("coin_req_addr", s_ra, 32'h300);
        for (int k = 0; k < 20 && pop_pc_log.size() == 0; k++) cycle(1'b0, 32'h0);
        check("coin_delivered", 32'(pop_pc_log.size() != 0), 32'd1);
        check("coin_first_pc", pop_pc_log[0], 32'h300);
        check("coin_first_inst", pop_data_log[0], 32'h300 ^ DATA_KEY);

        // Misaligned redirect stalls while the outstanding response is drained.
        mem_hold = 1'b1;
        cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h102);
        mem_hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 32'h0);
            check($sformatf("mis%0d_flag", k), 32'(s_mis), 32'd1);
            check($sformatf("mis%0d_req_valid", k), 32'(s_rv), 32'd0);
            check($sformatf("mis%0d_addr", k), s_ra, 32'h102);
            check($sformatf("mis%0d_inst_valid", k), 32'(s_iv), 32'd0);
        end
        cycle(1'b1, 32'h200);
        cycle(1'b0, 32'h0);
        check("realign_flag", 32'(s_mis), 32'd0);
        check("realign_req_valid", 32'(s_rv), 32'd1);
        check("realign_addr", s_ra, 32'h200);

        // Address wrap at the top of memory.
        cycle(1'b1, 32'hFFFF_FFFC);
        clear_logs();
        repeat (8) cycle(1'b0, 32'h0);
        check("wrap_req_count", 32'(req_log.size() >= 2), 32'd1);
        check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
        check("wrap_req1", req_log[1], 32'h0000_0000);
        check("wrap_pc0", pop_pc_log[0], 32'hFFFF_FFFC);
        check("wrap_pc1", pop_pc_log[1], 32'h0000_0000);
        check("wrap_inst1", pop_data_log[1], 32'h0000_0000 ^ DATA_KEY);

        // Reset in the middle of traffic abandons everything.
        do_reset("midrun");
        cycle(1'b0, 32'h0);
        check("midrun_req_addr", s_ra, 32'h0);
        check("midrun_inst_valid", 32'(s_iv), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
